// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a read-only ibus and a read/write dbus,
// with round-robin or dbus-first arbitration and registered memory-side outputs.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ibus_valid,
    input  logic [WIDTH-1:0] ibus_addr,
    output logic [WIDTH-1:0] ibus_rdata,
    output logic             ibus_done,
    input  logic             dbus_valid,
    input  logic [WIDTH-1:0] dbus_addr,
    input  logic [WIDTH-1:0] dbus_wdata,
    input  logic             dbus_wstrobe,
    output logic [WIDTH-1:0] dbus_rdata,
    output logic             dbus_done,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wstrobe,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_done
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    state_t           state_q, state_d;
    logic             last_d_q, last_d_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_wstrobe_q, mem_wstrobe_d;
    logic [WIDTH-1:0] ibus_rdata_q, ibus_rdata_d;
    logic [WIDTH-1:0] dbus_rdata_q, dbus_rdata_d;
    logic             ibus_done_q, ibus_done_d;
    logic             dbus_done_q, dbus_done_d;
    logic             i_el, d_el, pick_d;
    always_comb begin
        // a requester seeing its done this cycle has not yet dropped valid, so it is masked
        i_el          = ibus_valid && !ibus_done_q;
        d_el          = dbus_valid && !dbus_done_q;
        pick_d        = d_el && (!i_el || (FIXED_PRIO != 0) || !last_d_q);
        state_d       = state_q;
        last_d_d      = last_d_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrobe_d = mem_wstrobe_q;
        ibus_rdata_d  = ibus_rdata_q;
        dbus_rdata_d  = dbus_rdata_q;
        ibus_done_d   = 1'b0;
        dbus_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_wstrobe_d = 1'b0;
                if (pick_d) begin
                    state_d       = GRANT_D;
                    last_d_d      = 1'b1;
                    mem_addr_d    = dbus_addr;
                    mem_wdata_d   = dbus_wdata;
                    mem_wstrobe_d = dbus_wstrobe;
                end else if (i_el) begin
                    state_d    = GRANT_I;
                    last_d_d   = 1'b0;
                    mem_addr_d = ibus_addr;
                end
            end
            GRANT_I: if (mem_done) begin
                state_d       = IDLE;
                ibus_rdata_d  = mem_rdata;
                ibus_done_d   = 1'b1;
                mem_wstrobe_d = 1'b0;
            end
            GRANT_D: if (mem_done) begin
                state_d       = IDLE;
                dbus_rdata_d  = mem_rdata;
                dbus_done_d   = 1'b1;
                mem_wstrobe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_d_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrobe_q <= 1'b0;
            ibus_rdata_q  <= '0;
            dbus_rdata_q  <= '0;
            ibus_done_q   <= 1'b0;
            dbus_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrobe_q <= mem_wstrobe_d;
            ibus_rdata_q  <= ibus_rdata_d;
            dbus_rdata_q  <= dbus_rdata_d;
            ibus_done_q   <= ibus_done_d;
            dbus_done_q   <= dbus_done_d;
        end
    end
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrobe = mem_wstrobe_q;
    assign ibus_rdata  = ibus_rdata_q;
    assign dbus_rdata  = dbus_rdata_q;
    assign ibus_done   = ibus_done_q;
    assign dbus_done   = dbus_done_q;
endmodule
